// File: rtl/overlay_out_collector_pkg.sv
// Shared sizing and FSM encoding for the overlay output collector.
// Optional lane masking is enabled with the OVERLAY_LANE_MASK_EN macro.
package overlay_out_collector_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PE_NUM     = 8;
    localparam int OOC_LANES  = PE_NUM;
    localparam int OOC_DW     = 2 * DATA_WIDTH;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ooc_state_t;

endpackage

// File: rtl/overlay_out_collector_bank.sv
// One storage bank of the ping-pong collector: vector store, full flag, lane read mux.
// Under OVERLAY_LANE_MASK_EN the bank also keeps the lane mask of its vector.
module overlay_out_collector_bank
    import overlay_out_collector_pkg::*;
#(
    parameter int LANES = OOC_LANES,
    parameter int DW    = OOC_DW,
    parameter int LW    = $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                clr,
    input  logic [LANES*DW-1:0] wdata,
`ifdef OVERLAY_LANE_MASK_EN
    input  logic [LANES-1:0]    wmask,
    output logic [LANES-1:0]    mask,
`endif
    input  logic [LW-1:0]       rlane,
    output logic [DW-1:0]       rdata,
    output logic                is_full
);

    logic [DW-1:0] data_r [LANES];
    logic          full_r;

    // Vector store; a write wins over a free so a same-cycle refill is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                data_r[k] <= '0;
            end
        end else if (we) begin
            full_r <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                data_r[k] <= wdata[k*DW +: DW];
            end
        end else if (clr) begin
            full_r <= 1'b0;
        end
    end

`ifdef OVERLAY_LANE_MASK_EN
    logic [LANES-1:0] mask_r;

    // Lane mask captured together with the vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
        end else if (we) begin
            mask_r <= wmask;
        end
    end

    assign mask = mask_r;
`endif

    assign rdata   = data_r[rlane];
    assign is_full = full_r;

endmodule

// File: rtl/overlay_out_collector.sv
// Double-buffered parallel-in/serial-out collector for the PE-array output stage.
// Define OVERLAY_LANE_MASK_EN to add the lane_mask input (sparse lane emission).
module overlay_out_collector
    import overlay_out_collector_pkg::*;
#(
    parameter int LANES = OOC_LANES,
    parameter int DW    = OOC_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      p_in_v,
    input  logic [LANES*DW-1:0]       p_in,
`ifdef OVERLAY_LANE_MASK_EN
    input  logic [LANES-1:0]          lane_mask,
`endif
    input  logic                      s_out_ready,
    output logic                      s_out_v,
    output logic [DW-1:0]             s_out,
    output logic [$clog2(LANES)-1:0]  s_out_lane,
    output logic                      s_out_last,
    output logic                      busy,
    output logic                      full,
    output logic                      overflow
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    ooc_state_t    state_r, state_s;
    logic          wr_bank_r, rd_bank_r;
    logic [LW-1:0] lane_r, lane_s;
    logic          overflow_r, busy_r, full_r;

    logic [1:0]    we_s, clr_s, bank_full_s, full_nxt_s;
    logic [DW-1:0] bank_rdata_s [2];
    logic          cap_s, acc_s, drop_s, xfer_s, last_s, fin_s, other_full_s;
    logic [LW-1:0] start_lane_s, restart_lane_s, step_lane_s;

`ifdef OVERLAY_LANE_MASK_EN
    logic [LANES-1:0] bank_mask_s [2];
    logic [LANES-1:0] cur_mask_s, nxt_mask_s;

    function automatic logic [LW-1:0] lowest_set(input logic [LANES-1:0] m);
        logic [LW-1:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) r = LW'(i);
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] next_set_above(input logic [LANES-1:0] m,
                                                     input logic [LW-1:0] cur);
        logic [LW-1:0] r;
        r = cur;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = LW'(i);
        end
        return r;
    endfunction

    function automatic logic any_above(input logic [LANES-1:0] m, input logic [LW-1:0] cur);
        logic r;
        r = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i] && (i > int'(cur))) r = 1'b1;
        end
        return r;
    endfunction

    // A vector with no lanes to emit would never drain, so it is not captured at all.
    assign cap_s          = load && p_in_v && (|lane_mask);
    assign cur_mask_s     = bank_mask_s[rd_bank_r];
    assign nxt_mask_s     = (acc_s && (wr_bank_r != rd_bank_r)) ? lane_mask
                                                                 : bank_mask_s[!rd_bank_r];
    assign last_s         = !any_above(cur_mask_s, lane_r);
    assign start_lane_s   = lowest_set(lane_mask);
    assign restart_lane_s = lowest_set(nxt_mask_s);
    assign step_lane_s    = next_set_above(cur_mask_s, lane_r);
`else
    assign cap_s          = load && p_in_v;
    assign last_s         = (lane_r == LAST_LANE);
    assign start_lane_s   = '0;
    assign restart_lane_s = '0;
    assign step_lane_s    = lane_r + LW'(1);
`endif

    assign xfer_s = (state_r == DRAIN) && s_out_ready;
    assign fin_s  = xfer_s && last_s;
    // The write bank is only occupied when both are; then it is the one being drained.
    assign acc_s  = cap_s && (!bank_full_s[wr_bank_r] || (fin_s && (rd_bank_r == wr_bank_r)));
    assign drop_s = cap_s && !acc_s;
    assign other_full_s = bank_full_s[!rd_bank_r] || (acc_s && (wr_bank_r != rd_bank_r));

    assign we_s       = {acc_s && wr_bank_r, acc_s && !wr_bank_r};
    assign clr_s      = {fin_s && rd_bank_r, fin_s && !rd_bank_r};
    assign full_nxt_s = we_s | (bank_full_s & ~clr_s);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        overlay_out_collector_bank #(
            .LANES (LANES),
            .DW    (DW),
            .LW    (LW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (we_s[b]),
            .clr     (clr_s[b]),
            .wdata   (p_in),
`ifdef OVERLAY_LANE_MASK_EN
            .wmask   (lane_mask),
            .mask    (bank_mask_s[b]),
`endif
            .rlane   (lane_r),
            .rdata   (bank_rdata_s[b]),
            .is_full (bank_full_s[b])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: keep draining without a bubble while the other bank has data.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (acc_s) state_s = DRAIN; else state_s = IDLE;
            DRAIN:   if (fin_s && !other_full_s) state_s = IDLE; else state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // Lane counter next value.
    always_comb begin
        lane_s = lane_r;
        if (state_r == IDLE) begin
            if (acc_s) lane_s = start_lane_s; else lane_s = '0;
        end else if (xfer_s) begin
            if (fin_s) lane_s = restart_lane_s; else lane_s = step_lane_s;
        end else begin
            lane_s = lane_r;
        end
    end

    // Bank pointers, lane counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            lane_r     <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            if (acc_s) wr_bank_r <= !wr_bank_r;
            if (fin_s) rd_bank_r <= !rd_bank_r;
            if (drop_s) overflow_r <= 1'b1;
            lane_r <= lane_s;
            busy_r <= |full_nxt_s;
            full_r <= &full_nxt_s;
        end
    end

    // FSM outputs: serial stream driven only while draining.
    always_comb begin
        s_out_v    = 1'b0;
        s_out      = '0;
        s_out_lane = '0;
        s_out_last = 1'b0;
        if (state_r == DRAIN) begin
            s_out_v    = 1'b1;
            s_out      = bank_rdata_s[rd_bank_r];
            s_out_lane = lane_r;
            s_out_last = last_s;
        end else begin
            s_out_v    = 1'b0;
        end
    end

    assign busy     = busy_r;
    assign full     = full_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_overlay_out_collector.sv
// Self-checking bench: directed vector table, bounded corner sequences and
// randomized traffic against a queue-based reference model.
module tb_overlay_out_collector;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int LW    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic                p_in_v = 1'b0;
    logic [LANES*DW-1:0] p_in = '0;
    logic                s_out_ready = 1'b0;
    logic                s_out_v;
    logic [DW-1:0]       s_out;
    logic [LW-1:0]       s_out_lane;
    logic                s_out_last, busy, full, overflow;
`ifdef OVERLAY_LANE_MASK_EN
    logic [LANES-1:0]    lane_mask = 4'hF;
`endif

    int n_pass  = 0;
    int n_total = 0;

    overlay_out_collector #(.LANES(LANES), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .p_in_v      (p_in_v),
        .p_in        (p_in),
`ifdef OVERLAY_LANE_MASK_EN
        .lane_mask   (lane_mask),
`endif
        .s_out_ready (s_out_ready),
        .s_out_v     (s_out_v),
        .s_out       (s_out),
        .s_out_lane  (s_out_lane),
        .s_out_last  (s_out_last),
        .busy        (busy),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                rst, ld, vin;
        logic [LANES*DW-1:0] p;
        logic                rdy;
        logic                ev;
        logic [DW-1:0]       ed;
        logic [LW-1:0]       el;
        logic                elast, eb, ef, eo;
    } vec_t;

    vec_t tbl[$];

    localparam logic [LANES*DW-1:0] VA = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [LANES*DW-1:0] VB = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [LANES*DW-1:0] VC = {32'd12, 32'd11, 32'd10, 32'd9};
    localparam logic [LANES*DW-1:0] VZ = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic l, input logic v, input logic [LANES*DW-1:0] p,
                       input logic rd, input logic ev, input logic [DW-1:0] ed, input logic [LW-1:0] el,
                       input logic elast, input logic eb, input logic ef, input logic eo);
        vec_t t;
        t.rst = r; t.ld = l; t.vin = v; t.p = p; t.rdy = rd;
        t.ev = ev; t.ed = ed; t.el = el; t.elast = elast; t.eb = eb; t.ef = ef; t.eo = eo;
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_out(input string tag, input logic ev, input logic [DW-1:0] ed,
                           input logic [LW-1:0] el, input logic elast, input logic eb,
                           input logic ef, input logic eo);
        check({tag, " flags"}, {59'd0, s_out_v, s_out_last, busy, full, overflow},
              {59'd0, ev, elast, eb, ef, eo});
        if (ev) begin
            check({tag, " data"}, {32'd0, s_out}, {32'd0, ed});
            check({tag, " lane"}, {62'd0, s_out_lane}, {62'd0, el});
        end
    endtask

    // Reference model: a FIFO of at most two whole vectors plus a read position.
    logic [LANES*DW-1:0] mq[$];
    int                  mpos = 0;
    bit                  movf = 1'b0;

    task automatic model_edge(input logic r, input logic l, input logic v,
                              input logic [LANES*DW-1:0] p, input logic rd);
        if (r) begin
            mq.delete();
            mpos = 0;
            movf = 1'b0;
        end else begin
            if ((mq.size() > 0) && rd) begin
                mpos++;
                if (mpos == LANES) begin
                    void'(mq.pop_front());
                    mpos = 0;
                end
            end
            if (l && v) begin
                if (mq.size() < 2) mq.push_back(p);
                else movf = 1'b1;
            end
        end
    endtask

    task automatic model_cmp(input int c);
        logic [LANES*DW-1:0] cur;
        logic                mv;
        mv  = (mq.size() > 0);
        cur = mv ? mq[0] : '0;
        cmp_out($sformatf("rnd%0d", c), mv, cur[mpos*DW +: DW], LW'(mpos),
                mv && (mpos == LANES - 1), mv, mq.size() == 2, movf);
    endtask

    initial begin
        // reset, single-vector latency/order
        add(1,0,0,VZ,1, 0,0,0,0,0,0,0);
        add(0,1,1,VA,1, 1,1,0,0,1,0,0);
        add(0,0,0,VZ,1, 1,2,1,0,1,0,0);
        add(0,0,0,VZ,1, 1,3,2,0,1,0,0);
        add(0,0,0,VZ,1, 1,4,3,1,1,0,0);
        add(0,0,0,VZ,1, 0,0,0,0,0,0,0);
        // capture B coincident with A's final transfer: no bubble, full stays 0
        add(0,1,1,VA,1, 1,1,0,0,1,0,0);
        add(0,0,0,VZ,1, 1,2,1,0,1,0,0);
        add(0,0,0,VZ,1, 1,3,2,0,1,0,0);
        add(0,0,0,VZ,1, 1,4,3,1,1,0,0);
        add(0,1,1,VB,1, 1,5,0,0,1,0,0);
        add(0,0,0,VZ,1, 1,6,1,0,1,0,0);
        add(0,0,0,VZ,1, 1,7,2,0,1,0,0);
        add(0,0,0,VZ,1, 1,8,3,1,1,0,0);
        add(0,0,0,VZ,1, 0,0,0,0,0,0,0);
        // overrun with ready low: third vector dropped, sticky overflow
        add(0,1,1,VA,0, 1,1,0,0,1,0,0);
        add(0,1,1,VB,0, 1,1,0,0,1,1,0);
        add(0,1,1,VC,0, 1,1,0,0,1,1,1);
        add(0,0,0,VZ,1, 1,2,1,0,1,1,1);
        add(0,0,0,VZ,1, 1,3,2,0,1,1,1);
        add(0,0,0,VZ,1, 1,4,3,1,1,1,1);
        add(0,0,0,VZ,1, 1,5,0,0,1,0,1);
        add(0,0,0,VZ,1, 1,6,1,0,1,0,1);
        add(0,0,0,VZ,1, 1,7,2,0,1,0,1);
        add(0,0,0,VZ,1, 1,8,3,1,1,0,1);
        add(0,0,0,VZ,1, 0,0,0,0,0,0,1);
        add(1,0,0,VZ,1, 0,0,0,0,0,0,0);
        // ready toggling: words held while ready is low
        add(0,1,1,VA,1, 1,1,0,0,1,0,0);
        add(0,0,0,VZ,0, 1,1,0,0,1,0,0);
        add(0,0,0,VZ,0, 1,1,0,0,1,0,0);
        add(0,0,0,VZ,1, 1,2,1,0,1,0,0);
        add(0,0,0,VZ,0, 1,2,1,0,1,0,0);
        add(0,0,0,VZ,1, 1,3,2,0,1,0,0);
        add(0,0,0,VZ,1, 1,4,3,1,1,0,0);
        add(0,0,0,VZ,0, 1,4,3,1,1,0,0);
        add(0,0,0,VZ,1, 0,0,0,0,0,0,0);
        // reset mid-drain (with a simultaneous capture) then a fresh vector
        add(0,1,1,VA,1, 1,1,0,0,1,0,0);
        add(0,0,0,VZ,1, 1,2,1,0,1,0,0);
        add(0,0,0,VZ,1, 1,3,2,0,1,0,0);
        add(1,1,1,VC,1, 0,0,0,0,0,0,0);
        add(0,1,1,VB,1, 1,5,0,0,1,0,0);
        add(0,0,0,VZ,1, 1,6,1,0,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; load = tbl[i].ld; p_in_v = tbl[i].vin;
            p_in = tbl[i].p; s_out_ready = tbl[i].rdy;
            step();
            cmp_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el,
                    tbl[i].elast, tbl[i].eb, tbl[i].ef, tbl[i].eo);
        end

        // bounded wait for the end of a vector
        begin
            bit got_last;
            rst = 1'b1; load = 1'b0; p_in_v = 1'b0; s_out_ready = 1'b1;
            step();
            rst = 1'b0; load = 1'b1; p_in_v = 1'b1; p_in = VC;
            step();
            load = 1'b0; p_in_v = 1'b0;
            got_last = s_out_last;
            for (int k = 0; k < 10 && !got_last; k++) begin
                step();
                got_last = s_out_last;
            end
            check("last_seen", {63'd0, got_last}, 64'd1);
            check("last_word", {32'd0, s_out}, 64'd12);
        end

`ifdef OVERLAY_LANE_MASK_EN
        rst = 1'b1; step();
        rst = 1'b0; lane_mask = 4'b1010; load = 1'b1; p_in_v = 1'b1; p_in = VA;
        step();
        load = 1'b0; p_in_v = 1'b0;
        cmp_out("mask_l1", 1, 2, 1, 0, 1, 0, 0);
        step();
        cmp_out("mask_l3", 1, 4, 3, 1, 1, 0, 0);
        step();
        cmp_out("mask_end", 0, 0, 0, 0, 0, 0, 0);
        lane_mask = 4'b0000; load = 1'b1; p_in_v = 1'b1; p_in = VB;
        step();
        load = 1'b0; p_in_v = 1'b0;
        cmp_out("mask_zero", 0, 0, 0, 0, 0, 0, 0);
        step();
        cmp_out("mask_zero2", 0, 0, 0, 0, 0, 0, 0);
        lane_mask = 4'hF;
`endif

        // randomized traffic against the reference model
        rst = 1'b1; load = 1'b0; p_in_v = 1'b0; s_out_ready = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0, VZ, 1'b0);
        step();
        model_cmp(-1);
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 59) == 0);
            load        = 1'($urandom_range(0, 1));
            p_in_v      = ($urandom_range(0, 9) < 7);
            s_out_ready = ($urandom_range(0, 9) < 6);
            p_in        = {$urandom, $urandom, $urandom, $urandom};
            model_edge(rst, load, p_in_v, p_in, s_out_ready);
            step();
            model_cmp(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
